// File: rtl/matmul_partition_mul_arb.sv
// matmul_partition_mul_arb: round-robin arbiter that shares one pipelined signed
// multiplier among N_REQ requesters. A {valid, id} tag pipeline runs alongside the
// multiplier so every product leaves tagged with its owner, in issue order.
// Optional per-requester grant counters: define MATMUL_PARTITION_MUL_ARB_STAT_EN.
module matmul_partition_mul_arb #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned MUL_LAT = 1,
  parameter int unsigned DATA_W  = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ*DATA_W-1:0]     req_a,
  input  logic [N_REQ*DATA_W-1:0]     req_b,
  output logic                        mul_ce,
  output logic [DATA_W-1:0]           mul_din0,
  output logic [DATA_W-1:0]           mul_din1,
  input  logic [DATA_W-1:0]           mul_dout,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [$clog2(N_REQ)-1:0]    rsp_id,
  output logic [DATA_W-1:0]           rsp_data
`ifdef MATMUL_PARTITION_MUL_ARB_STAT_EN
  ,
  output logic [N_REQ*16-1:0]         grant_cnt
`endif
);

  localparam int unsigned IdW = $clog2(N_REQ);

  logic [IdW-1:0]     last_grant_q, last_grant_d;
  logic [IdW-1:0]     gnt_idx;
  logic [IdW-1:0]     cand;
  logic               gnt_any;
  logic               xfer;
  logic [MUL_LAT-1:0] tag_vld_q;
  logic [IdW-1:0]     tag_id_q [MUL_LAT];

  // A pending response that cannot leave freezes the multiplier and tag pipe together.
  always_comb begin
    rsp_valid = tag_vld_q[MUL_LAT-1];
    rsp_id    = tag_id_q[MUL_LAT-1];
    rsp_data  = mul_dout;
    mul_ce    = ~(rsp_valid & ~rsp_ready);
  end

  // Round-robin search starting just above the last granted requester.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = IdW'((32'(last_grant_q) + i) % N_REQ);
      if (!gnt_any && req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // Handshake and operand steering; reset forces everything quiet.
  always_comb begin
    xfer         = gnt_any & mul_ce & ~reset;
    req_ready    = '0;
    mul_din0     = '0;
    mul_din1     = '0;
    last_grant_d = last_grant_q;
    if (xfer) begin
      req_ready[gnt_idx] = 1'b1;
      mul_din0           = req_a[32'(gnt_idx) * DATA_W +: DATA_W];
      mul_din1           = req_b[32'(gnt_idx) * DATA_W +: DATA_W];
      last_grant_d       = gnt_idx;
    end
  end

  // Tag pipeline mirrors the multiplier latency; stage 0 takes a bubble when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_vld_q    <= '0;
      last_grant_q <= IdW'(N_REQ - 1);
      for (int unsigned i = 0; i < MUL_LAT; i++) tag_id_q[i] <= '0;
    end else if (mul_ce) begin
      tag_vld_q[0] <= xfer;
      tag_id_q[0]  <= gnt_idx;
      for (int unsigned i = 1; i < MUL_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end
      last_grant_q <= last_grant_d;
    end
  end

`ifdef MATMUL_PARTITION_MUL_ARB_STAT_EN
  logic [15:0] cnt_q [N_REQ];

  // Per-requester transfer counters, saturating at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (req_ready[i] && cnt_q[i] != 16'hFFFF) cnt_q[i] <= cnt_q[i] + 16'd1;
      end
    end
  end

  // Flatten counters onto the packed output.
  always_comb begin
    grant_cnt = '0;
    for (int unsigned i = 0; i < N_REQ; i++) grant_cnt[i*16 +: 16] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_matmul_partition_mul_arb.sv
// Self-checking bench for matmul_partition_mul_arb with a registered multiplier model
// and a queue-based reference model of grants and responses.
module tb_matmul_partition_mul_arb;
  localparam int N   = 4;
  localparam int LAT = 2;
  localparam int W   = 32;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic           mul_ce;
  logic [W-1:0]   mul_din0, mul_din1, mul_dout;
  logic           rsp_valid;
  logic           rsp_ready = 1'b1;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_data;
`ifdef MATMUL_PARTITION_MUL_ARB_STAT_EN
  logic [N*16-1:0] grant_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  matmul_partition_mul_arb #(.N_REQ(N), .MUL_LAT(LAT), .DATA_W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .mul_ce    (mul_ce),
    .mul_din0  (mul_din0),
    .mul_din1  (mul_din1),
    .mul_dout  (mul_dout),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
`ifdef MATMUL_PARTITION_MUL_ARB_STAT_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Shared multiplier: LAT register stages, all gated by mul_ce, never reset.
  logic [W-1:0] mpipe [LAT];
  always @(posedge clk) begin
    if (mul_ce) begin
      mpipe[0] <= mul_din0 * mul_din1;
      for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
  end
  assign mul_dout = mpipe[LAT-1];

  // Reference model: in-flight products as a queue of (id, product, age in enabled cycles).
  typedef struct {int id; logic [W-1:0] prod; int age;} ent_t;
  ent_t m_q[$];
  int   m_last = N - 1;

  function automatic bit m_rv();
    return m_q.size() > 0 && m_q[0].age == LAT;
  endfunction
  function automatic bit m_ce();
    return !(m_rv() && !rsp_ready);
  endfunction
  function automatic int m_gnt();
    if (reset || !m_ce()) return -1;
    for (int i = 1; i <= N; i++) begin
      int c;
      c = (m_last + i) % N;
      if (req_valid[c]) return c;
    end
    return -1;
  endfunction

  initial begin
    bit rv, ce;
    int g;
    logic [W-1:0] pa, pb;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_q.delete();
        m_last = N - 1;
      end else begin
        rv = m_rv();
        ce = m_ce();
        g  = m_gnt();
        if (ce) begin
          if (rv) void'(m_q.pop_front());
          foreach (m_q[i]) m_q[i].age++;
          if (g >= 0) begin
            pa = req_a[g*W +: W];
            pb = req_b[g*W +: W];
            m_q.push_back('{g, pa * pb, 1});
            m_last = g;
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; req_valid = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    req_valid = '0; rsp_ready = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    req_valid = 4'hF;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = $urandom; req_b[i*W +: W] = $urandom;
    end
    #2;
    n_cmp++; if (req_ready !== 4'h0) begin n_err++; $display("FAIL reset_ready got %b want 0000", req_ready); end
    n_cmp++; if (mul_ce !== 1'b1) begin n_err++; $display("FAIL reset_ce got %b want 1", mul_ce); end
    n_cmp++; if (mul_din0 !== 32'h0) begin n_err++; $display("FAIL reset_din0 got %h want 0", mul_din0); end
    n_cmp++; if (mul_din1 !== 32'h0) begin n_err++; $display("FAIL reset_din1 got %h want 0", mul_din1); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    n_cmp++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL reset_rsp_id got %0d want 0", rsp_id); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0; req_valid = '0;
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0100; req_a[2*W +: W] = 32'd7; req_b[2*W +: W] = -32'sd3; rsp_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL single_ready got %b want 0100", req_ready); end
    n_cmp++; if (mul_din0 !== 32'd7 || mul_din1 !== 32'hFFFFFFFD) begin
      n_err++; $display("FAIL single_din got %h/%h want 00000007/fffffffd", mul_din0, mul_din1);
    end
    @(posedge clk); #1 req_valid = '0;
    for (int k = 1; k < LAT; k++) begin
      @(negedge clk);
      n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_early got %b want 0", rsp_valid); end
      @(posedge clk);
    end
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got %b want 1", rsp_valid); end
    n_cmp++; if (rsp_id !== 2'd2) begin n_err++; $display("FAIL single_id got %0d want 2", rsp_id); end
    n_cmp++; if (rsp_data !== 32'hFFFFFFEB) begin n_err++; $display("FAIL single_data got %h want ffffffeb", rsp_data); end
    idle(3);
  endtask

  task automatic test_fairness();
    int nrsp = 0;
    do_reset();
    req_valid = 4'hF; rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = 32'(i + 1); req_b[i*W +: W] = 32'(10 * i + 3);
    end
    for (int k = 0; k < 20; k++) begin
      if (k == 8) req_valid = '0;
      @(negedge clk);
      if (k < 8) begin
        n_cmp++; if (req_ready !== 4'(1 << (k % 4))) begin
          n_err++; $display("FAIL fair_grant%0d got %b want %b", k, req_ready, 4'(1 << (k % 4)));
        end
      end
      if (rsp_valid === 1'b1) begin
        n_cmp++; if (rsp_id !== 2'(nrsp % 4)) begin
          n_err++; $display("FAIL fair_id%0d got %0d want %0d", nrsp, rsp_id, nrsp % 4);
        end
        nrsp++;
      end
      @(posedge clk); #1;
    end
    n_cmp++; if (nrsp != 8) begin n_err++; $display("FAIL fair_count got %0d want 8", nrsp); end
  endtask

  task automatic test_stall();
    logic [W-1:0] prod;
    bit seen = 0;
    do_reset();
    req_valid = 4'b0010; rsp_ready = 1'b0;
    req_a[W +: W] = $urandom; req_b[W +: W] = $urandom;
    prod = req_a[W +: W] * req_b[W +: W];
    @(posedge clk); #1 req_valid = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin seen = 1; break; end
    end
    n_cmp++; if (!seen) begin n_err++; $display("FAIL stall_wait got no rsp_valid want rsp_valid within 10 cycles"); end
    req_valid = 4'hF;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if (mul_ce !== 1'b0) begin n_err++; $display("FAIL stall_ce%0d got %b want 0", k, mul_ce); end
      n_cmp++; if (req_ready !== 4'h0) begin n_err++; $display("FAIL stall_ready%0d got %b want 0000", k, req_ready); end
      n_cmp++; if (rsp_id !== 2'd1 || rsp_data !== prod) begin
        n_err++; $display("FAIL stall_hold%0d got %0d/%h want 1/%h", k, rsp_id, rsp_data, prod);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1; req_valid = '0;
    #1;
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== prod || mul_ce !== 1'b1) begin
      n_err++; $display("FAIL stall_release got v%b id%0d %h ce%b want v1 id1 %h ce1", rsp_valid, rsp_id, rsp_data,
                        mul_ce, prod);
    end
    @(negedge clk); #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL stall_dup got %b want 0", rsp_valid); end
    idle(2);
  endtask

  task automatic test_overflow();
    bit seen = 0;
    do_reset();
    req_valid = 4'b0001; rsp_ready = 1'b1;
    req_a[0 +: W] = 32'h7FFFFFFF; req_b[0 +: W] = 32'd2;
    @(posedge clk); #1 req_valid = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin seen = 1; break; end
    end
    n_cmp++; if (!seen || rsp_data !== 32'hFFFFFFFE || rsp_id !== 2'd0) begin
      n_err++; $display("FAIL overflow got seen%0d %h id%0d want seen1 fffffffe id0", seen, rsp_data, rsp_id);
    end
    idle(2);
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    do_reset();
    req_valid = 4'b1000; rsp_ready = 1'b0;
    req_a[3*W +: W] = 32'd5; req_b[3*W +: W] = 32'd6;
    @(posedge clk); #1 req_valid = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin seen = 1; break; end
    end
    n_cmp++; if (!seen) begin n_err++; $display("FAIL rmid_wait got no rsp_valid want rsp_valid within 10 cycles"); end
    req_valid = 4'hF;
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rmid_async got %b want 0", rsp_valid); end
    n_cmp++; if (mul_ce !== 1'b1 || req_ready !== 4'h0) begin
      n_err++; $display("FAIL rmid_quiet got ce%b rdy%b want ce1 rdy0000", mul_ce, req_ready);
    end
    @(posedge clk); #1;
    reset = 1'b0; req_valid = '0; rsp_ready = 1'b1;
    for (int k = 0; k < LAT + 3; k++) begin
      @(negedge clk);
      n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rmid_stale%0d got %b want 0", k, rsp_valid); end
    end
    idle(1);
  endtask

  task automatic test_random();
    int g;
    logic [N-1:0] erdy;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      req_valid = k < 380 ? N'($urandom_range(0, 15)) : '0;
      for (int i = 0; i < N; i++) begin
        req_a[i*W +: W] = $urandom; req_b[i*W +: W] = $urandom;
      end
      rsp_ready = k >= 380 || ($urandom_range(0, 9) < 7);
      @(negedge clk);
      g = m_gnt();
      erdy = '0;
      if (g >= 0) erdy[g] = 1'b1;
      n_cmp++; if (req_ready !== erdy) begin n_err++; $display("FAIL rnd_ready@%0d got %b want %b", k, req_ready, erdy); end
      n_cmp++; if (mul_ce !== m_ce()) begin n_err++; $display("FAIL rnd_ce@%0d got %b want %b", k, mul_ce, m_ce()); end
      if (g >= 0) begin
        n_cmp++; if (mul_din0 !== req_a[g*W +: W]) begin
          n_err++; $display("FAIL rnd_din0@%0d got %h want %h", k, mul_din0, req_a[g*W +: W]);
        end
      end
      n_cmp++; if (rsp_valid !== m_rv()) begin n_err++; $display("FAIL rnd_valid@%0d got %b want %b", k, rsp_valid, m_rv()); end
      if (m_rv() && rsp_valid === 1'b1) begin
        n_cmp++; if (rsp_id !== 2'(m_q[0].id) || rsp_data !== m_q[0].prod) begin
          n_err++; $display("FAIL rnd_rsp@%0d got %0d/%h want %0d/%h", k, rsp_id, rsp_data, m_q[0].id, m_q[0].prod);
        end
      end
    end
    n_cmp++; if (m_q.size() != 0) begin n_err++; $display("FAIL rnd_drain got %0d pending want 0", m_q.size()); end
  endtask

`ifdef MATMUL_PARTITION_MUL_ARB_STAT_EN
  task automatic test_stat();
    do_reset();
    req_valid = 4'b0010; rsp_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1 req_valid = '0;
    idle(4);
    n_cmp++; if (grant_cnt !== 64'h0000_0000_0005_0000) begin
      n_err++; $display("FAIL stat_cnt got %h want 0000000000050000", grant_cnt);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_stall();
    test_overflow();
    test_reset_mid();
    test_random();
`ifdef MATMUL_PARTITION_MUL_ARB_STAT_EN
    test_stat();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/matmul_partition_mul_arb.md
MATMUL_PARTITION_MUL_ARB -- requirements
Module: matmul_partition_mul_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters sharing one multiplier (2..8).
REQ-002 SHALL have parameter MUL_LAT, default 1, cycles from mul_ce-qualified issue to mul_dout valid (1..4).
REQ-003 SHALL have parameter DATA_W, default 32, operand and product width.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port req_valid  in  N_REQ  per-requester operand-pair valid.
REQ-007 SHALL have port req_ready  out  N_REQ  per-requester accept, one-hot or zero.
REQ-008 SHALL have port req_a  in  N_REQ*DATA_W  packed operand A; requester i at bits [i*DATA_W +: DATA_W].
REQ-009 SHALL have port req_b  in  N_REQ*DATA_W  packed operand B; same packing as req_a.
REQ-010 SHALL have port mul_ce  out  1  clock enable to the shared signed multiplier.
REQ-011 SHALL have ports mul_din0 and mul_din1  out  DATA_W  multiplier operands.
REQ-012 SHALL have port mul_dout  in  DATA_W  registered multiplier product, low DATA_W bits.
REQ-013 SHALL have port rsp_valid  out  1  product available.
REQ-014 SHALL have port rsp_ready  in  1  consumer accepts product.
REQ-015 SHALL have port rsp_id  out  clog2(N_REQ)  requester index owning rsp_data.
REQ-016 SHALL have port rsp_data  out  DATA_W  product, driven directly from mul_dout.

Function
REQ-017 SHALL define stall = rsp_valid AND NOT rsp_ready; mul_ce = NOT stall.
REQ-018 SHALL, when mul_ce=1 and any req_valid set, grant exactly one requester round-robin, searching from last_grant+1 upward with wrap at N_REQ-1 to 0.
REQ-019 SHALL assert req_ready[i] only for the granted requester and only when mul_ce=1; transfer occurs on req_valid[i] AND req_ready[i].
REQ-020 SHALL drive mul_din0/mul_din1 with the granted requester's req_a/req_b combinationally; zero when no grant.
REQ-021 SHALL update last_grant to the granted index on each transfer; unchanged otherwise.
REQ-022 SHALL carry a tag pipeline of MUL_LAT stages {valid, id}, advancing only when mul_ce=1; stage 0 loads {transfer, granted index}.
REQ-023 SHALL drive rsp_valid/rsp_id from the last tag stage; with no stall, transfer at edge t yields rsp_valid after edge t+MUL_LAT.
REQ-024 SHALL hold all tags, rsp_id and (via mul_ce=0) rsp_data stable while stalled; no request is granted during stall.
REQ-025 SHALL sustain one issue and one response per cycle with rsp_ready held high.
REQ-026 SHALL insert bubble tags (valid=0) on cycles with mul_ce=1 and no transfer; bubbles never produce rsp_valid.
REQ-027 SHALL never drop, duplicate or reorder responses; responses leave in issue order.
REQ-028 SHALL treat req_valid deassertion without transfer as legal (no grant, pointer unchanged).

Reset
REQ-029 SHALL, on reset assertion, asynchronously clear all tag valid bits, rsp_valid=0, rsp_id=0, last_grant=N_REQ-1 (requester 0 first priority).
REQ-030 SHALL during reset drive req_ready=0, mul_ce=1, mul_din0=mul_din1=0.
REQ-031 SHALL discard products in flight at reset; stale mul_dout after reset release SHALL not raise rsp_valid.

Configuration
REQ-032 SHALL, with MATMUL_PARTITION_MUL_ARB_STAT_EN defined, add port grant_cnt  out  N_REQ*16: per-requester transfer counters, saturating at 0xFFFF, cleared by reset.
REQ-033 SHALL, without MATMUL_PARTITION_MUL_ARB_STAT_EN, omit grant_cnt and all counter logic; all other behaviour identical.

Verification
REQ-034 SHALL test single requester: req 2 a=7, b=-3, rsp_ready=1 -> req_ready[2] same cycle, rsp_valid, rsp_id=2, rsp_data=0xFFFFFFEB after MUL_LAT cycles.
REQ-035 SHALL test fairness: all 4 requesters valid for 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3; 8 responses with matching ids.
REQ-036 SHALL test stall: rsp_ready=0 for 3 cycles with response pending -> mul_ce=0, req_ready=0, rsp_id/rsp_data stable; no loss after release.
REQ-037 SHALL test overflow wrap: a=0x7FFFFFFF, b=2 -> rsp_data=0xFFFFFFFE.
REQ-038 SHALL test reset mid-operation: reset with 1 tag in flight -> rsp_valid=0 immediately and after release until a new transfer.
REQ-039 SHALL test with STAT_EN: requester 1 granted 5 times -> grant_cnt[31:16]=5, others 0.
